// File: rtl/exec_if.sv
// Strobe/bus bundle between the front-end panel (master) and the execution back end (slave).
interface exec_if;
    logic [15:0] instruction;
    logic        Execute_St;
    logic        Overflow_St;
    logic        Reg_Store;
    logic [3:0]  dbg_sel;
    logic [3:0]  result;
    logic        Overflow;
    logic        illegal;
    logic        proto_err;
    logic        busy;
    logic [3:0]  dbg_data;

    modport master (
        output instruction, Execute_St, Overflow_St, Reg_Store, dbg_sel,
        input  result, Overflow, illegal, proto_err, busy, dbg_data
    );

    modport slave (
        input  instruction, Execute_St, Overflow_St, Reg_Store, dbg_sel,
        output result, Overflow, illegal, proto_err, busy, dbg_data
    );
endinterface

// File: rtl/exec_unit.sv
// Execution back end: latches an instruction on Execute_St, publishes overflow on
// Overflow_St and commits the result to the register file on Reg_Store.
module exec_unit (
    input  logic   clk,
    input  logic   rst_n,
    exec_if.slave  bus
);
    localparam int unsigned NREG = 16;
    localparam int unsigned W    = 4;
    localparam int unsigned OPW  = 4;
    localparam int unsigned RW   = $clog2(NREG);

    localparam logic [OPW-1:0] OP_ADD  = 4'h0;
    localparam logic [OPW-1:0] OP_SUB  = 4'h1;
    localparam logic [OPW-1:0] OP_AND  = 4'h2;
    localparam logic [OPW-1:0] OP_OR   = 4'h3;
    localparam logic [OPW-1:0] OP_XOR  = 4'h4;
    localparam logic [OPW-1:0] OP_NOT  = 4'h5;
    localparam logic [OPW-1:0] OP_SHL  = 4'h6;
    localparam logic [OPW-1:0] OP_SHR  = 4'h7;
    localparam logic [OPW-1:0] OP_LDI  = 4'h8;
    localparam logic [OPW-1:0] OP_ADDI = 4'h9;
    localparam logic [OPW-1:0] OP_MOV  = 4'hA;
    localparam logic [OPW-1:0] OP_RSV  = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMPUTED = 2'd1,
        S_CHECKED  = 2'd2
    } state_e;

    state_e         state_q;
    logic [W-1:0]   regs_q [NREG];
    logic [W-1:0]   result_q;
    logic           ovf_pend_q;
    logic           overflow_q;
    logic           illegal_q;
    logic           proto_err_q;
    logic           busy_q;
    logic [RW-1:0]  rd_q;
    logic           wr_en_q;

    logic [OPW-1:0] op_c;
    logic [RW-1:0]  rd_c;
    logic [RW-1:0]  ra_c;
    logic [W-1:0]   imm_c;
    logic [W-1:0]   a_c;
    logic [W-1:0]   b_c;
    logic [W-1:0]   res_c;
    logic           ovf_c;
    logic           writes_c;

    assign op_c     = bus.instruction[15:12];
    assign rd_c     = bus.instruction[11:8];
    assign ra_c     = bus.instruction[7:4];
    assign imm_c    = bus.instruction[3:0];
    assign a_c      = regs_q[ra_c];
    assign b_c      = regs_q[imm_c];
    assign writes_c = (op_c <= OP_MOV);

    // ALU; NOP and reserved opcodes leave the displayed result untouched.
    always_comb begin
        res_c = result_q;
        ovf_c = 1'b0;
        case (op_c)
            OP_ADD: begin
                res_c = W'(a_c + b_c);
                ovf_c = (a_c[W-1] == b_c[W-1]) && (res_c[W-1] != a_c[W-1]);
            end
            OP_SUB: begin
                res_c = W'(a_c - b_c);
                ovf_c = (a_c[W-1] != b_c[W-1]) && (res_c[W-1] != a_c[W-1]);
            end
            OP_AND:  res_c = a_c & b_c;
            OP_OR:   res_c = a_c | b_c;
            OP_XOR:  res_c = a_c ^ b_c;
            OP_NOT:  res_c = ~a_c;
            OP_SHL:  res_c = W'(a_c << imm_c[1:0]);
            OP_SHR:  res_c = W'(a_c >> imm_c[1:0]);
            OP_LDI:  res_c = imm_c;
            OP_ADDI: begin
                res_c = W'(a_c + imm_c);
                ovf_c = (a_c[W-1] == imm_c[W-1]) && (res_c[W-1] != a_c[W-1]);
            end
            OP_MOV:  res_c = a_c;
            default: res_c = result_q;
        endcase
    end

    // Strobe sequencer; Execute_St > Overflow_St > Reg_Store, losers ignored silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            regs_q      <= '{default: '0};
            result_q    <= '0;
            ovf_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            proto_err_q <= 1'b0;
            busy_q      <= 1'b0;
            rd_q        <= '0;
            wr_en_q     <= 1'b0;
        end else if (bus.Execute_St) begin
            state_q    <= S_COMPUTED;
            busy_q     <= 1'b1;
            result_q   <= res_c;
            ovf_pend_q <= ovf_c;
            overflow_q <= 1'b0;
            illegal_q  <= (op_c >= OP_RSV);
            rd_q       <= rd_c;
            wr_en_q    <= writes_c;
        end else if (bus.Overflow_St) begin
            if (state_q == S_COMPUTED) begin
                state_q    <= S_CHECKED;
                overflow_q <= ovf_pend_q;
            end else begin
                proto_err_q <= 1'b1;
            end
        end else if (bus.Reg_Store) begin
            if (state_q == S_CHECKED) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                if (wr_en_q) begin
                    regs_q[rd_q] <= result_q;
                end
            end else begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.Overflow  = overflow_q;
    assign bus.illegal   = illegal_q;
    assign bus.proto_err = proto_err_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_data  = regs_q[bus.dbg_sel];
endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit: strobe sequences with hand-computed results.
module tb_exec_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    exec_if bus ();

    exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [3:0] idx, input logic [3:0] exp);
        bus.dbg_sel = idx;
        #1;
        chk($sformatf("R%0d", idx), 16'(bus.dbg_data), 16'(exp));
    endtask

    // Drive strobes for exactly one rising edge, then scramble the instruction bus.
    task automatic pulse(input logic e, input logic o, input logic r, input logic [15:0] ins);
        bus.instruction = ins;
        bus.Execute_St  = e;
        bus.Overflow_St = o;
        bus.Reg_Store   = r;
        @(negedge clk);
        bus.Execute_St  = 1'b0;
        bus.Overflow_St = 1'b0;
        bus.Reg_Store   = 1'b0;
        bus.instruction = 16'hFFFF;
    endtask

    task automatic do_exec(input logic [15:0] ins);
        pulse(1'b1, 1'b0, 1'b0, ins);
    endtask

    task automatic do_ovf();
        pulse(1'b0, 1'b1, 1'b0, 16'hFFFF);
    endtask

    task automatic do_store();
        pulse(1'b0, 1'b0, 1'b1, 16'hFFFF);
    endtask

    task automatic run(input logic [15:0] ins);
        do_exec(ins);
        do_ovf();
        do_store();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp           = 0;
        n_mis           = 0;
        rst_n           = 1'b0;
        bus.instruction = 16'h0000;
        bus.Execute_St  = 1'b0;
        bus.Overflow_St = 1'b0;
        bus.Reg_Store   = 1'b0;
        bus.dbg_sel     = 4'd0;
        @(negedge clk);
        do_reset();

        chk("rst_result", 16'(bus.result), 16'h0);
        chk("rst_ovf", 16'(bus.Overflow), 16'h0);
        chk("rst_illegal", 16'(bus.illegal), 16'h0);
        chk("rst_proto", 16'(bus.proto_err), 16'h0);
        chk("rst_busy", 16'(bus.busy), 16'h0);
        chk_reg(4'd1, 4'h0);

        // LDI R1,5 with back-to-back strobes
        do_exec(16'h8105);
        chk("ldi_result", 16'(bus.result), 16'h5);
        chk("ldi_ovf", 16'(bus.Overflow), 16'h0);
        chk("ldi_busy", 16'(bus.busy), 16'h1);
        do_ovf();
        chk("ldi_ovf2", 16'(bus.Overflow), 16'h0);
        do_store();
        chk("ldi_busy_done", 16'(bus.busy), 16'h0);
        chk_reg(4'd1, 4'h5);

        // 5 + 4 = 9: positive overflow, still written wrapped
        run(16'h8204);
        do_exec(16'h0312);
        chk("add_result", 16'(bus.result), 16'h9);
        do_ovf();
        chk("add_ovf", 16'(bus.Overflow), 16'h1);
        do_store();
        chk_reg(4'd3, 4'h9);
        chk("add_ovf_hold", 16'(bus.Overflow), 16'h1);
        chk("add_result_hold", 16'(bus.result), 16'h9);

        do_exec(16'h8108);
        chk("exec_clears_ovf", 16'(bus.Overflow), 16'h0);
        do_ovf();
        do_store();
        run(16'h8201);
        // -8 - 1 = 7: negative overflow
        do_exec(16'h1412);
        chk("sub_ovf_result", 16'(bus.result), 16'h7);
        do_ovf();
        chk("sub_ovf_flag", 16'(bus.Overflow), 16'h1);
        do_store();
        chk_reg(4'd4, 4'h7);

        run(16'h8103);
        do_exec(16'h1412);
        chk("sub_result", 16'(bus.result), 16'h2);
        do_ovf();
        chk("sub_flag", 16'(bus.Overflow), 16'h0);
        do_store();
        chk_reg(4'd4, 4'h2);

        // R1=3, R2=1 for the logic/shift group
        run(16'h2512);
        chk("and", 16'(bus.result), 16'h1);
        run(16'h3512);
        chk("or", 16'(bus.result), 16'h3);
        run(16'h4512);
        chk("xor", 16'(bus.result), 16'h2);
        run(16'h5510);
        chk("not", 16'(bus.result), 16'hC);
        run(16'h6512);
        chk("shl", 16'(bus.result), 16'hC);
        run(16'h7511);
        chk("shr", 16'(bus.result), 16'h1);
        run(16'h9517);
        chk("addi", 16'(bus.result), 16'hA);
        chk("addi_ovf", 16'(bus.Overflow), 16'h1);
        run(16'hA510);
        chk("mov", 16'(bus.result), 16'h3);
        chk("mov_ovf", 16'(bus.Overflow), 16'h0);
        chk_reg(4'd5, 4'h3);
        run(16'hB600);
        chk("nop_result", 16'(bus.result), 16'h3);
        chk_reg(4'd6, 4'h0);

        // Reg_Store from IDLE
        do_store();
        chk("store_idle_proto", 16'(bus.proto_err), 16'h1);
        chk("store_idle_busy", 16'(bus.busy), 16'h0);
        chk_reg(4'd5, 4'h3);
        run(16'h8105);
        chk("proto_sticky", 16'(bus.proto_err), 16'h1);
        chk_reg(4'd1, 4'h5);
        do_reset();
        chk("proto_cleared", 16'(bus.proto_err), 16'h0);
        chk_reg(4'd1, 4'h0);

        // Overflow_St twice
        do_exec(16'h8105);
        do_ovf();
        chk("ovf_once_proto", 16'(bus.proto_err), 16'h0);
        do_ovf();
        chk("ovf_twice_proto", 16'(bus.proto_err), 16'h1);
        do_store();
        chk_reg(4'd1, 4'h5);
        do_reset();

        // Abort: second Execute_St replaces the pending ADD
        run(16'h8105);
        run(16'h8204);
        do_exec(16'h0312);
        chk("abort_first", 16'(bus.result), 16'h9);
        do_exec(16'h8207);
        chk("abort_second", 16'(bus.result), 16'h7);
        do_ovf();
        do_store();
        chk_reg(4'd2, 4'h7);
        chk_reg(4'd3, 4'h0);
        chk("abort_proto", 16'(bus.proto_err), 16'h0);

        // Execute_St and Reg_Store together: Execute wins, no write, no error
        do_exec(16'h8306);
        do_ovf();
        pulse(1'b1, 1'b0, 1'b1, 16'h8409);
        chk("simul_busy", 16'(bus.busy), 16'h1);
        chk("simul_proto", 16'(bus.proto_err), 16'h0);
        chk("simul_result", 16'(bus.result), 16'h9);
        chk_reg(4'd3, 4'h0);
        do_ovf();
        do_store();
        chk_reg(4'd4, 4'h9);
        chk_reg(4'd3, 4'h0);

        // Reserved opcode
        do_exec(16'hF123);
        chk("illegal_flag", 16'(bus.illegal), 16'h1);
        chk("illegal_result", 16'(bus.result), 16'h9);
        do_ovf();
        chk("illegal_ovf", 16'(bus.Overflow), 16'h0);
        do_store();
        chk_reg(4'd1, 4'h5);
        chk("illegal_hold", 16'(bus.illegal), 16'h1);
        chk("illegal_busy", 16'(bus.busy), 16'h0);

        // Reset in the middle of an ADD (5 + 7 = C)
        do_exec(16'h0312);
        chk("midop_result", 16'(bus.result), 16'hC);
        chk("midop_illegal", 16'(bus.illegal), 16'h0);
        do_reset();
        chk("midrst_result", 16'(bus.result), 16'h0);
        chk("midrst_ovf", 16'(bus.Overflow), 16'h0);
        chk("midrst_busy", 16'(bus.busy), 16'h0);
        chk_reg(4'd1, 4'h0);
        chk_reg(4'd2, 4'h0);
        chk_reg(4'd3, 4'h0);
        do_store();
        chk("midrst_store_proto", 16'(bus.proto_err), 16'h1);
        chk_reg(4'd3, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
